// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC actuator sequencer.
package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAT,
    COOL,
    OVERRUN
  } hvac_state_e;

  localparam int MIN_ON_D      = 4;
  localparam int MIN_OFF_D     = 6;
  localparam int FAN_OVERRUN_D = 3;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/hvac_timer.sv
// Loadable down-counter that parks at zero; used for dwell, lockout and fan overrun.
module hvac_timer
  import hvac_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hvac_actuator.sv
// Heat/cool/fan sequencer enforcing minimum on-time, compressor lockout and fan run-on.
module hvac_actuator
  import hvac_pkg::*;
#(
  parameter int MIN_ON      = MIN_ON_D,
  parameter int MIN_OFF     = MIN_OFF_D,
  parameter int FAN_OVERRUN = FAN_OVERRUN_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic heating,
  input  logic cooling,
  output logic heater_on,
  output logic compressor_on,
  output logic fan_on,
  output logic fault
);

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] OVR_LD   = CNT_W'(FAN_OVERRUN - 1);

  hvac_state_e state, nxt;
  logic        heat_req, cool_req;
  logic        dwell_zero, lock_zero, ovr_zero;
  logic        dwell_load, lock_load, ovr_load;

  // Conflicting requests count as no request at all.
  assign heat_req = heating & ~cooling;
  assign cool_req = cooling & ~heating;

  always_comb begin
    nxt = state;
    case (state)
      IDLE, OVERRUN: begin
        if (heat_req) begin
          nxt = HEAT;
        end else if (cool_req && lock_zero) begin
          nxt = COOL;
        end else if (state == OVERRUN && ovr_zero) begin
          nxt = IDLE;
        end
      end
      HEAT: if (dwell_zero && !heat_req) nxt = OVERRUN;
      COOL: if (dwell_zero && !cool_req) nxt = OVERRUN;
      default: nxt = IDLE;
    endcase
  end

  assign dwell_load = (nxt == HEAT && state != HEAT) || (nxt == COOL && state != COOL);
  assign ovr_load   = (nxt == OVERRUN) && (state != OVERRUN);
  assign lock_load  = (state == COOL) && (nxt == OVERRUN);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      heater_on     <= 1'b0;
      compressor_on <= 1'b0;
      fan_on        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= nxt;
      heater_on     <= (nxt == HEAT);
      compressor_on <= (nxt == COOL);
      fan_on        <= (nxt != IDLE);
      fault         <= heating & cooling;
    end
  end

  hvac_timer #(.W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (DWELL_LD),
    .zero     (dwell_zero)
  );

  hvac_timer #(.W(CNT_W)) u_lockout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lock_load),
    .load_val (LOCK_LD),
    .zero     (lock_zero)
  );

  hvac_timer #(.W(CNT_W)) u_overrun (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ovr_load),
    .load_val (OVR_LD),
    .zero     (ovr_zero)
  );

endmodule

// File: tb/tb_hvac_actuator.sv
// Directed scoreboard bench for hvac_actuator; expected vectors are {heater, compressor, fan, fault}.
module tb_hvac_actuator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic heating = 1'b0;
  logic cooling = 1'b0;
  logic heater_on, compressor_on, fan_on, fault;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sbQueue[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hvac_actuator #(
    .MIN_ON      (4),
    .MIN_OFF     (6),
    .FAN_OVERRUN (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .heating       (heating),
    .cooling       (cooling),
    .heater_on     (heater_on),
    .compressor_on (compressor_on),
    .fan_on        (fan_on),
    .fault         (fault)
  );

  task automatic applyStimulus(input logic h, input logic c, input logic r,
                               input logic [3:0] exp, input string tag);
    exp_t e;
    heating = h;
    cooling = c;
    rst_n   = r;
    e.exp   = exp;
    e.tag   = tag;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [3:0] obs;
    obs = {heater_on, compressor_on, fan_on, fault};
    if (sbQueue.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%b required=none", obs);
    end else begin
      e = sbQueue.pop_front();
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%b required=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input logic h, input logic c, input logic r,
                      input logic [3:0] exp, input string tag);
    applyStimulus(h, c, r, exp, tag);
    checkOutput();
  endtask

  initial begin
    step(0, 0, 0, 4'b0000, "reset_0");
    step(0, 0, 0, 4'b0000, "reset_1");

    // heat cycle: short request still gives 4 heater cycles, then 3 fan-only
    step(1, 0, 1, 4'b1010, "heat_1");
    step(1, 0, 1, 4'b1010, "heat_2");
    step(0, 0, 1, 4'b1010, "heat_3");
    step(0, 0, 1, 4'b1010, "heat_4");
    step(0, 0, 1, 4'b0010, "heat_ovr_1");
    step(0, 0, 1, 4'b0010, "heat_ovr_2");
    step(0, 0, 1, 4'b0010, "heat_ovr_3");
    step(0, 0, 1, 4'b0000, "heat_idle");

    // illegal input from IDLE
    step(1, 1, 1, 4'b0001, "illegal_fault");
    step(0, 0, 1, 4'b0000, "illegal_clear");

    // cool with lockout on re-request
    for (int i = 0; i < 10; i++) step(0, 1, 1, 4'b0110, $sformatf("cool_%0d", i + 1));
    step(0, 0, 1, 4'b0010, "cool_ovr_1");
    step(0, 0, 1, 4'b0010, "cool_ovr_2");
    step(0, 1, 1, 4'b0010, "lock_ovr_3");
    step(0, 1, 1, 4'b0000, "lock_idle_1");
    step(0, 1, 1, 4'b0000, "lock_idle_2");
    step(0, 1, 1, 4'b0000, "lock_idle_3");
    step(0, 1, 1, 4'b0000, "lock_idle_4");
    step(0, 1, 1, 4'b0110, "lock_release");

    // reset at cycle 3 of COOL
    step(0, 1, 1, 4'b0110, "cool_cyc2");
    step(0, 1, 1, 4'b0110, "cool_cyc3");
    step(0, 1, 0, 4'b0000, "rst_mid_cool");
    step(0, 1, 1, 4'b0110, "cool_after_rst");

    // reset mid-OVERRUN must discard the lockout
    step(0, 1, 1, 4'b0110, "cool_b_2");
    step(0, 1, 1, 4'b0110, "cool_b_3");
    step(0, 1, 1, 4'b0110, "cool_b_4");
    step(0, 0, 1, 4'b0010, "cool_b_ovr");
    step(0, 0, 0, 4'b0000, "rst_mid_ovr");
    step(0, 1, 1, 4'b0110, "cool_no_lock");
    step(0, 1, 1, 4'b0110, "cool_c_2");
    step(0, 1, 1, 4'b0110, "cool_c_3");
    step(0, 1, 1, 4'b0110, "cool_c_4");
    step(0, 0, 0, 4'b0000, "reset_2");

    // heat to cool changeover via one fan-only cycle
    step(1, 0, 1, 4'b1010, "chg_heat_1");
    step(1, 0, 1, 4'b1010, "chg_heat_2");
    step(1, 0, 1, 4'b1010, "chg_heat_3");
    step(1, 0, 1, 4'b1010, "chg_heat_4");
    step(0, 1, 1, 4'b0010, "chg_fan_only");
    step(0, 1, 1, 4'b0110, "chg_cool_1");
    step(0, 1, 1, 4'b0110, "chg_cool_2");
    step(0, 1, 1, 4'b0110, "chg_cool_3");
    step(0, 1, 1, 4'b0110, "chg_cool_4");

    // cool to heat changeover; heat is not subject to the lockout
    step(1, 0, 1, 4'b0010, "chg2_fan_only");
    step(1, 0, 1, 4'b1010, "chg2_heat_1");
    step(0, 0, 1, 4'b1010, "chg2_heat_2");
    step(0, 0, 1, 4'b1010, "chg2_heat_3");
    step(0, 0, 1, 4'b1010, "chg2_heat_4");
    step(0, 0, 1, 4'b0010, "pre_ovr_1");
    step(0, 0, 1, 4'b0010, "pre_ovr_2");

    // heat request in overrun cycle 2 pre-empts the run-on
    step(1, 0, 1, 4'b1010, "preempt_heat");
    step(0, 0, 1, 4'b1010, "preempt_heat_2");
    step(0, 0, 1, 4'b1010, "preempt_heat_3");
    step(0, 0, 1, 4'b1010, "preempt_heat_4");
    step(0, 0, 1, 4'b0010, "preempt_ovr_1");
    step(0, 0, 1, 4'b0010, "preempt_ovr_2");
    step(0, 0, 1, 4'b0010, "preempt_ovr_3");
    step(0, 0, 1, 4'b0000, "preempt_idle");

    // conflicting inputs while heating end the heat after dwell and flag fault
    step(1, 0, 1, 4'b1010, "both_heat_1");
    step(1, 0, 1, 4'b1010, "both_heat_2");
    step(1, 0, 1, 4'b1010, "both_heat_3");
    step(1, 0, 1, 4'b1010, "both_heat_4");
    step(1, 1, 1, 4'b0011, "both_exit");
    step(1, 1, 1, 4'b0011, "both_hold");
    step(0, 0, 1, 4'b0010, "both_ovr_3");
    step(0, 0, 1, 4'b0000, "both_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
